// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and its memory.
// The fetch unit is the master: it raises MemReq with MemAddr and holds
// both until the memory answers with MemValid/MemData.
interface fetch_unit_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [15:0] MemData;
  logic        MemValid;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemData,
    input  MemValid
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemData,
    output MemValid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Reads 16-bit instruction words from instruction memory at PcCurrent and
// assembles them into a 32-bit IrOut for decode. PcNext feeds the external
// PC register, which loads it every cycle, so the PC only advances in the
// cycle the final word of an instruction is accepted (or on a redirect).
//
// Optional feature: define FETCH_IMM_EN to support two-word instructions,
// marked by bit IMM_FLAG_BIT of the first word. Without it every
// instruction is one word, IrOut[31:16] is always zero and IMM_FLAG_BIT is
// ignored.
module fetch_unit #(
  parameter int IMM_FLAG_BIT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PcCurrent,
  output logic [31:0] PcNext,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  fetch_unit_if.master mem,
  output logic [31:0] IrOut,
  output logic        IrValid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
`ifdef FETCH_IMM_EN
    FETCH_HI = 2'd2,
`endif
    DONE     = 2'd3
  } state_t;

  state_t      state;
  logic        isTwoWord;
  logic [31:0] pcIncrement;

`ifdef FETCH_IMM_EN
  // The immediate flag travels in the first word as it arrives.
  assign isTwoWord = mem.MemData[IMM_FLAG_BIT];
`else
  // Single-word build: the flag bit carries no meaning.
  logic unusedImmFlag;
  assign unusedImmFlag = mem.MemData[IMM_FLAG_BIT];
  assign isTwoWord     = 1'b0;
`endif

  // Next-PC selection: redirect wins, otherwise advance by the instruction
  // length in the cycle its final word is accepted, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    pcIncrement = 32'd0;
    if (!Rst && mem.MemValid) begin
      case (state)
        FETCH_LO: if (!isTwoWord) pcIncrement = 32'd1;
`ifdef FETCH_IMM_EN
        FETCH_HI: pcIncrement = 32'd2;
`endif
        default:  pcIncrement = 32'd0;
      endcase
    end
    // 32-bit addition wraps naturally, so 0xFFFFFFFF + 1 gives 0.
    PcNext = BranchTaken ? BranchTarget : (PcCurrent + pcIncrement);
  end

  // Fetch sequencer with registered memory request and instruction outputs.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state       <= IDLE;
      IrOut       <= 32'd0;
      IrValid     <= 1'b0;
      mem.MemReq  <= 1'b0;
      mem.MemAddr <= 32'd0;
    end else if (BranchTaken) begin
      // Abandon whatever is in flight; a word arriving this cycle is dropped.
      state      <= IDLE;
      IrValid    <= 1'b0;
      mem.MemReq <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!Stall) begin
            state       <= FETCH_LO;
            mem.MemReq  <= 1'b1;
            mem.MemAddr <= PcCurrent;
          end
        end

        FETCH_LO: begin
          // Stall is deliberately ignored here: an issued read always completes.
          if (mem.MemValid) begin
            IrOut <= {16'h0000, mem.MemData};
            if (isTwoWord) begin
`ifdef FETCH_IMM_EN
              state       <= FETCH_HI;
              mem.MemAddr <= PcCurrent + 32'd1;
`endif
            end else begin
              state      <= DONE;
              mem.MemReq <= 1'b0;
              IrValid    <= 1'b1;
            end
          end
        end

`ifdef FETCH_IMM_EN
        FETCH_HI: begin
          if (mem.MemValid) begin
            IrOut[31:16] <= mem.MemData;
            state        <= DONE;
            mem.MemReq   <= 1'b0;
            IrValid      <= 1'b1;
          end
        end
`endif

        DONE: begin
          // PcCurrent already advanced at the accept edge, so the next fetch
          // issues straight from here with no IDLE bubble.
          if (!Stall) begin
            state       <= FETCH_LO;
            mem.MemReq  <= 1'b1;
            mem.MemAddr <= PcCurrent;
            IrValid     <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          mem.MemReq <= 1'b0;
          IrValid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Models the external PC register
// (reset value 32, loads PcNext every cycle) and drives the memory side
// with hand-timed responses. Inputs change 1 time unit after the rising
// edge; outputs are checked 1 time unit later.
module tb_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic [31:0] PcCurrent;
  logic [31:0] PcNext;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IrOut;
  logic        IrValid;

  int checks = 0;
  int fails  = 0;

  fetch_unit_if mem ();

  fetch_unit #(.IMM_FLAG_BIT(15)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PcCurrent    (PcCurrent),
    .PcNext       (PcNext),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .mem          (mem),
    .IrOut        (IrOut),
    .IrValid      (IrValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External PC register.
  always @(posedge Clk) begin
    if (Rst) PcCurrent <= 32'd32;
    else     PcCurrent <= PcNext;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    Rst          = 1'b1;
    Stall        = 1'b0;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h0000_0500;
    mem.MemValid = 1'b1;
    mem.MemData  = 16'hFFFF;
    tick();
    tick();
    settle();
    checks++; if (IrOut !== 32'd0) begin fails++; $display("FAIL reset_irout: got %h expected %h", IrOut, 32'd0); end
    checks++; if (IrValid !== 1'b0) begin fails++; $display("FAIL reset_irvalid: got %b expected 0", IrValid); end
    checks++; if (mem.MemReq !== 1'b0) begin fails++; $display("FAIL reset_memreq: got %b expected 0", mem.MemReq); end
    checks++; if (PcCurrent !== 32'd32) begin fails++; $display("FAIL reset_pc: got %h expected %h", PcCurrent, 32'd32); end
    Rst          = 1'b0;
    BranchTaken  = 1'b0;
    mem.MemValid = 1'b0;
    mem.MemData  = 16'h0000;
  endtask

  // Single-word fetch at 32, memory answers two cycles after the request.
  task automatic test_single_word();
    tick();
    settle();
    checks++; if (mem.MemReq !== 1'b1) begin fails++; $display("FAIL single_memreq: got %b expected 1", mem.MemReq); end
    checks++; if (mem.MemAddr !== 32'd32) begin fails++; $display("FAIL single_memaddr: got %h expected %h", mem.MemAddr, 32'd32); end
    checks++; if (PcNext !== 32'd32) begin fails++; $display("FAIL single_pc_hold: got %h expected %h", PcNext, 32'd32); end
    tick();
    settle();
    checks++; if (mem.MemReq !== 1'b1 || mem.MemAddr !== 32'd32) begin fails++; $display("FAIL single_req_stable: got req=%b addr=%h expected req=1 addr=%h", mem.MemReq, mem.MemAddr, 32'd32); end
    tick();
    mem.MemValid = 1'b1;
    mem.MemData  = 16'h1234;
    Stall        = 1'b1;
    settle();
    checks++; if (PcNext !== 32'd33) begin fails++; $display("FAIL single_pcnext: got %h expected %h", PcNext, 32'd33); end
    tick();
    mem.MemValid = 1'b0;
    settle();
    checks++; if (IrOut !== 32'h0000_1234) begin fails++; $display("FAIL single_irout: got %h expected %h", IrOut, 32'h0000_1234); end
    checks++; if (IrValid !== 1'b1) begin fails++; $display("FAIL single_irvalid: got %b expected 1", IrValid); end
    checks++; if (PcCurrent !== 32'd33) begin fails++; $display("FAIL single_pc_loaded: got %h expected %h", PcCurrent, 32'd33); end
  endtask

  // Hold DONE for three cycles, then release and expect an immediate request.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      checks++; if (IrOut !== 32'h0000_1234 || IrValid !== 1'b1 || mem.MemReq !== 1'b0) begin
        fails++; $display("FAIL stall_hold_%0d: got ir=%h v=%b req=%b expected ir=00001234 v=1 req=0", i, IrOut, IrValid, mem.MemReq);
      end
      if (i < 2) tick();
    end
    Stall = 1'b0;
    tick();
    settle();
    checks++; if (mem.MemReq !== 1'b1 || mem.MemAddr !== 32'd33) begin fails++; $display("FAIL stall_release: got req=%b addr=%h expected req=1 addr=%h", mem.MemReq, mem.MemAddr, 32'd33); end
    checks++; if (IrValid !== 1'b0) begin fails++; $display("FAIL stall_release_irvalid: got %b expected 0", IrValid); end
  endtask

  // Redirect during FETCH_LO with a simultaneous memory word.
  task automatic test_branch();
    BranchTaken  = 1'b1;
    BranchTarget = 32'h0000_0100;
    mem.MemValid = 1'b1;
    mem.MemData  = 16'h5555;
    settle();
    checks++; if (PcNext !== 32'h0000_0100) begin fails++; $display("FAIL branch_pcnext: got %h expected %h", PcNext, 32'h0000_0100); end
    tick();
    BranchTaken  = 1'b0;
    mem.MemValid = 1'b0;
    Stall        = 1'b1;
    settle();
    checks++; if (IrValid !== 1'b0) begin fails++; $display("FAIL branch_irvalid: got %b expected 0", IrValid); end
    checks++; if (IrOut !== 32'h0000_1234) begin fails++; $display("FAIL branch_discard: got %h expected %h", IrOut, 32'h0000_1234); end
    checks++; if (mem.MemReq !== 1'b0) begin fails++; $display("FAIL branch_memreq: got %b expected 0", mem.MemReq); end
    tick();
    settle();
    checks++; if (mem.MemReq !== 1'b0) begin fails++; $display("FAIL idle_stall: got %b expected 0", mem.MemReq); end
    Stall = 1'b0;
    tick();
    settle();
    checks++; if (mem.MemReq !== 1'b1 || mem.MemAddr !== 32'h0000_0100) begin fails++; $display("FAIL branch_refetch: got req=%b addr=%h expected req=1 addr=%h", mem.MemReq, mem.MemAddr, 32'h0000_0100); end
    // Move back to 32 for the 0x8001 instruction.
    BranchTaken  = 1'b1;
    BranchTarget = 32'd32;
    tick();
    BranchTaken = 1'b0;
    tick();
    settle();
    checks++; if (mem.MemAddr !== 32'd32 || mem.MemReq !== 1'b1) begin fails++; $display("FAIL branch_to_32: got req=%b addr=%h expected req=1 addr=%h", mem.MemReq, mem.MemAddr, 32'd32); end
  endtask

`ifdef FETCH_IMM_EN
  // Two-word instruction 0x8001 / 0xBEEF at 32/33.
  task automatic test_imm_word();
    mem.MemValid = 1'b1;
    mem.MemData  = 16'h8001;
    settle();
    checks++; if (PcNext !== 32'd32) begin fails++; $display("FAIL imm_lo_pcnext: got %h expected %h", PcNext, 32'd32); end
    tick();
    mem.MemValid = 1'b0;
    settle();
    checks++; if (mem.MemReq !== 1'b1 || mem.MemAddr !== 32'd33) begin fails++; $display("FAIL imm_hi_addr: got req=%b addr=%h expected req=1 addr=%h", mem.MemReq, mem.MemAddr, 32'd33); end
    checks++; if (IrValid !== 1'b0) begin fails++; $display("FAIL imm_hi_irvalid: got %b expected 0", IrValid); end
    mem.MemValid = 1'b1;
    mem.MemData  = 16'hBEEF;
    Stall        = 1'b1;
    settle();
    checks++; if (PcNext !== 32'd34) begin fails++; $display("FAIL imm_pcnext: got %h expected %h", PcNext, 32'd34); end
    tick();
    mem.MemValid = 1'b0;
    settle();
    checks++; if (IrOut !== 32'hBEEF_8001 || IrValid !== 1'b1) begin fails++; $display("FAIL imm_irout: got ir=%h v=%b expected ir=%h v=1", IrOut, IrValid, 32'hBEEF_8001); end
  endtask
`else
  // Without two-word support 0x8001 is a plain single-word instruction.
  task automatic test_imm_word();
    mem.MemValid = 1'b1;
    mem.MemData  = 16'h8001;
    Stall        = 1'b1;
    settle();
    checks++; if (PcNext !== 32'd33) begin fails++; $display("FAIL noimm_pcnext: got %h expected %h", PcNext, 32'd33); end
    tick();
    mem.MemValid = 1'b0;
    settle();
    checks++; if (IrOut !== 32'h0000_8001 || IrValid !== 1'b1) begin fails++; $display("FAIL noimm_irout: got ir=%h v=%b expected ir=%h v=1", IrOut, IrValid, 32'h0000_8001); end
    checks++; if (mem.MemReq !== 1'b0) begin fails++; $display("FAIL noimm_memreq: got %b expected 0", mem.MemReq); end
  endtask
`endif

  // Redirect from DONE to 0xFFFFFFFF, fetch there and wrap to 0.
  task automatic test_wrap();
    BranchTaken  = 1'b1;
    BranchTarget = 32'hFFFF_FFFF;
    settle();
    checks++; if (PcNext !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_branch_pcnext: got %h expected %h", PcNext, 32'hFFFF_FFFF); end
    tick();
    BranchTaken = 1'b0;
    Stall       = 1'b0;
    settle();
    checks++; if (IrValid !== 1'b0) begin fails++; $display("FAIL wrap_done_abort: got %b expected 0", IrValid); end
    tick();
    settle();
    checks++; if (mem.MemAddr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_memaddr: got %h expected %h", mem.MemAddr, 32'hFFFF_FFFF); end
    mem.MemValid = 1'b1;
    mem.MemData  = 16'h0042;
    settle();
    checks++; if (PcNext !== 32'h0000_0000) begin fails++; $display("FAIL wrap_pcnext: got %h expected %h", PcNext, 32'h0000_0000); end
    tick();
    mem.MemValid = 1'b0;
    settle();
    checks++; if (IrOut !== 32'h0000_0042 || IrValid !== 1'b1 || PcCurrent !== 32'd0) begin fails++; $display("FAIL wrap_done: got ir=%h v=%b pc=%h expected ir=00000042 v=1 pc=00000000", IrOut, IrValid, PcCurrent); end
  endtask

  // DONE with Stall=0 goes straight back to FETCH_LO at the new PC.
  task automatic test_back_to_back();
    tick();
    settle();
    checks++; if (mem.MemReq !== 1'b1 || mem.MemAddr !== 32'd0 || IrValid !== 1'b0) begin fails++; $display("FAIL b2b_issue: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", mem.MemReq, mem.MemAddr, IrValid); end
  endtask

  // Reset while a fetch is outstanding, with a late memory word.
  task automatic test_reset_mid_fetch();
    Rst          = 1'b1;
    mem.MemValid = 1'b1;
    mem.MemData  = 16'h7777;
    tick();
    Rst = 1'b0;
    settle();
    checks++; if (mem.MemReq !== 1'b0 || IrOut !== 32'd0 || IrValid !== 1'b0) begin fails++; $display("FAIL midreset_clear: got req=%b ir=%h v=%b expected req=0 ir=00000000 v=0", mem.MemReq, IrOut, IrValid); end
    checks++; if (PcNext !== 32'd32) begin fails++; $display("FAIL midreset_late_valid: got %h expected %h", PcNext, 32'd32); end
    tick();
    mem.MemValid = 1'b0;
    settle();
    checks++; if (mem.MemReq !== 1'b1 || mem.MemAddr !== 32'd32 || IrOut !== 32'd0) begin fails++; $display("FAIL midreset_refetch: got req=%b addr=%h ir=%h expected req=1 addr=00000020 ir=00000000", mem.MemReq, mem.MemAddr, IrOut); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_branch();
    test_imm_word();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: IMM_FLAG_BIT, default 15, bit of the first instruction word that marks a two-word (immediate) instruction.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 PcCurrent  input  32  current PC, from the PC register output.
REQ-005 PcNext  output  32  next PC, driven into the PC register data input, which loads it every cycle.
REQ-006 Stall  input  1  downstream not ready; blocks new fetch issue and holds the delivered instruction.
REQ-007 BranchTaken  input  1  redirect request, single-cycle pulse.
REQ-008 BranchTarget  input  32  redirect address; valid when BranchTaken=1.
REQ-009 MemReq  output  1  instruction-memory read request.
REQ-010 MemAddr  output  32  word address of the request.
REQ-011 MemData  input  16  returned instruction word.
REQ-012 MemValid  input  1  MemData valid this cycle; ignored when MemReq=0.
REQ-013 IrOut  output  32  fetched instruction: [15:0] first word, [31:16] second word or zero.
REQ-014 IrValid  output  1  IrOut holds a complete instruction for decode.

Function
REQ-015 FSM states SHALL be IDLE, FETCH_LO, FETCH_HI, DONE.
REQ-016 PcNext SHALL be combinational: BranchTarget if BranchTaken=1; else PcCurrent+N in the cycle the final word of an N-word instruction is accepted; else PcCurrent.
REQ-017 PC arithmetic SHALL be modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-018 IDLE: Stall=0 -> FETCH_LO with MemReq=1, MemAddr=PcCurrent; Stall=1 -> stay, MemReq=0.
REQ-019 FETCH_LO: MemReq and MemAddr held stable until MemValid=1; first word latched into IrOut[15:0], IrOut[31:16] cleared.
REQ-020 FETCH_LO accept: first word bit IMM_FLAG_BIT=1 (and two-word support enabled) -> FETCH_HI, MemAddr=PcCurrent+1; else -> DONE, PcNext=PcCurrent+1.
REQ-021 FETCH_HI: on MemValid=1 second word latched into IrOut[31:16] -> DONE, PcNext=PcCurrent+2 (base PcCurrent unchanged since FETCH_LO).
REQ-022 DONE: IrValid=1; Stall=1 -> stay, IrOut/IrValid held; Stall=0 -> FETCH_LO issuing at the updated PcCurrent (back-to-back, no IDLE bubble).
REQ-023 IrValid SHALL be 1 only in DONE; MemReq 0 in IDLE and DONE.
REQ-024 BranchTaken=1 in any state: in-flight fetch abandoned, a same-cycle MemValid word discarded, IrValid=0 next cycle, next state IDLE.
REQ-025 Stall SHALL NOT abort an in-flight fetch; it acts only in IDLE and DONE.

Reset
REQ-026 Rst=1 sampled at an edge: state IDLE, IrOut=0, IrValid=0, MemReq=0; overrides BranchTaken and MemValid.
REQ-027 Reset mid-fetch SHALL drop MemReq the cycle after Rst is sampled; late MemValid ignored.
REQ-028 First fetch after Rst deasserts SHALL use PcCurrent as delivered by the PC register (reset value 32).

Configuration
REQ-029 Macro FETCH_IMM_EN defined: two-word instructions supported per REQ-020/021.
REQ-030 FETCH_IMM_EN undefined: FETCH_HI SHALL not exist, every instruction is one word, IrOut[31:16]=0, IMM_FLAG_BIT ignored.

Verification
REQ-031 Rst, then PcCurrent=32, MemValid 2 cycles after MemReq with MemData=0x1234 -> IrOut=0x00001234, IrValid=1, PcNext=33 in the accept cycle.
REQ-032 FETCH_IMM_EN: words 0x8001 then 0xBEEF at 32/33 -> IrOut=0xBEEF8001, PcNext=34, MemAddr 32 then 33.
REQ-033 BranchTaken, BranchTarget=0x100 during FETCH_LO with simultaneous MemValid -> word discarded, IrValid stays 0, PcNext=0x100, next fetch MemAddr=0x100.
REQ-034 Stall=1 in DONE for 3 cycles -> IrOut/IrValid stable, MemReq=0; Stall=0 -> next MemReq the following cycle.
REQ-035 PcCurrent=0xFFFFFFFF single-word accept -> PcNext=0x00000000; macro undefined with 0x8001 -> IrOut=0x00008001, PcNext=PcCurrent+1.
